dm_ctrl: RTL and testbench

Parametrised data-memory controller for the MIPS SoPC: the next generation of the single-cycle data RAM. It sits between the CPU data port (ce/we/sel/addr/data) and on-chip word storage. It adds configurable depth and read/write wait states, with a stall handshake back to the pipeline. An optional out-of-range address error flag can be compiled in.

---
 rtl/dm_ctrl_pkg.sv | 15 +
 rtl/dm_bank.sv | 27 ++
 rtl/dm_ctrl.sv | 137 +++++++++++++
 tb/tb_dm_ctrl.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/dm_ctrl_pkg.sv
// Shared widths, defaults and FSM state type for the data-memory controller.
// Optional feature macro: DM_ERR_EN (out-of-range address error flag).
package dm_ctrl_pkg;

    localparam int unsigned DM_DATA_W       = 32;
    localparam int unsigned DM_ADDR_W       = 32;
    localparam int unsigned DM_WAIT_DEFAULT = 2;

    typedef enum logic [1:0] {
        DM_IDLE = 2'd0,
        DM_BUSY = 2'd1,
        DM_DONE = 2'd2
    } dm_state_t;

endpackage

// File: rtl/dm_bank.sv
// DEPTH x 32 word storage: byte-lane masked synchronous write, asynchronous read.
module dm_bank
    import dm_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic [AW-1:0]        idx,
    input  logic [3:0]           wen,
    input  logic [DM_DATA_W-1:0] wdata,
    output logic [DM_DATA_W-1:0] rdata
);

    logic [DM_DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int unsigned lane = 0; lane < 4; lane++) begin
            if (wen[lane]) begin
                mem[idx][lane*8 +: 8] <= wdata[lane*8 +: 8];
            end
        end
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/dm_ctrl.sv
// Data-memory controller: configurable wait states with stall handshake.
// Optional feature macro: DM_ERR_EN (flags and suppresses out-of-range accesses).
module dm_ctrl
    import dm_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned WAIT  = DM_WAIT_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ce,
    input  logic                 we,
    input  logic [DM_ADDR_W-1:0] addr,
    input  logic [3:0]           sel,
    input  logic [DM_DATA_W-1:0] data_i,
    output logic [DM_DATA_W-1:0] data_o,
    output logic                 stall_o,
    output logic                 err_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW-1:0]        idx_in;
    logic                 oor_in;
    logic [AW-1:0]        bank_idx;
    logic [3:0]           bank_wen;
    logic [DM_DATA_W-1:0] bank_wdata;
    logic [DM_DATA_W-1:0] bank_rdata;

    assign idx_in = addr[AW+1:2];

`ifdef DM_ERR_EN
    logic unused_addr;
    assign oor_in      = |addr[DM_ADDR_W-1:AW+2];
    assign unused_addr = ^addr[1:0];
`else
    // Upper address bits are dropped, so accesses alias modulo DEPTH.
    logic unused_addr;
    assign oor_in      = 1'b0;
    assign unused_addr = ^{addr[DM_ADDR_W-1:AW+2], addr[1:0]};
`endif

    dm_bank #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_bank (
        .clk   (clk),
        .idx   (bank_idx),
        .wen   (bank_wen),
        .wdata (bank_wdata),
        .rdata (bank_rdata)
    );

    if (WAIT == 0) begin : g_nowait
        assign bank_idx   = idx_in;
        assign bank_wdata = data_i;
        assign bank_wen   = (ce && we && !oor_in) ? sel : '0;
        assign data_o     = (ce && !we && !oor_in) ? bank_rdata : '0;
        assign err_o      = ce && oor_in;
        assign stall_o    = 1'b0;
    end else begin : g_wait
        localparam logic [3:0] WAIT_M1 = 4'(WAIT - 1);

        dm_state_t            state;
        logic [3:0]           cnt;
        logic                 busy_q;
        logic                 err_q;
        logic [AW-1:0]        idx_q;
        logic                 we_q;
        logic                 oor_q;
        logic [3:0]           sel_q;
        logic [DM_DATA_W-1:0] wdata_q;
        logic                 access;

        // The access fires on the final BUSY edge; async reset drops state so
        // an in-flight write never reaches the bank.
        assign access     = (state == DM_BUSY) && (cnt == '0);
        assign bank_idx   = idx_q;
        assign bank_wdata = wdata_q;
        assign bank_wen   = (access && we_q && !oor_q) ? sel_q : '0;
        assign stall_o    = busy_q || ((state == DM_IDLE) && ce);
        assign err_o      = err_q;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                state   <= DM_IDLE;
                cnt     <= '0;
                busy_q  <= 1'b0;
                err_q   <= 1'b0;
                data_o  <= '0;
                idx_q   <= '0;
                we_q    <= 1'b0;
                oor_q   <= 1'b0;
                sel_q   <= '0;
                wdata_q <= '0;
            end else begin
                case (state)
                    DM_IDLE: begin
                        err_q <= 1'b0;
                        if (ce) begin
                            idx_q   <= idx_in;
                            we_q    <= we;
                            oor_q   <= oor_in;
                            sel_q   <= sel;
                            wdata_q <= data_i;
                            cnt     <= WAIT_M1;
                            busy_q  <= 1'b1;
                            state   <= DM_BUSY;
                        end
                    end
                    DM_BUSY: begin
                        if (cnt != '0) begin
                            cnt <= cnt - 4'd1;
                        end else begin
                            if (!we_q) begin
                                data_o <= oor_q ? '0 : bank_rdata;
                            end
                            err_q  <= oor_q;
                            busy_q <= 1'b0;
                            state  <= DM_DONE;
                        end
                    end
                    DM_DONE: begin
                        err_q <= 1'b0;
                        state <= DM_IDLE;
                    end
                    default: begin
                        busy_q <= 1'b0;
                        err_q  <= 1'b0;
                        state  <= DM_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dm_ctrl.sv
// Directed bench for dm_ctrl: WAIT=2 vector table, WAIT=0 and WAIT=3 reset sequences.
module tb_dm_ctrl;

`ifdef DM_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rst3 = 1'b0;
    logic        ce0 = 1'b0, ce2 = 1'b0, ce3 = 1'b0;
    logic        we = 1'b0;
    logic [31:0] addr = '0;
    logic [3:0]  sel = '0;
    logic [31:0] wdata = '0;
    logic [31:0] q0, q2, q3;
    logic        st0, st2, st3;
    logic        er0, er2, er3;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    dm_ctrl #(.DEPTH(1024), .WAIT(0)) u0 (
        .clk(clk), .rst(rst), .ce(ce0), .we(we), .addr(addr), .sel(sel),
        .data_i(wdata), .data_o(q0), .stall_o(st0), .err_o(er0)
    );
    dm_ctrl #(.DEPTH(1024), .WAIT(2)) u2 (
        .clk(clk), .rst(rst), .ce(ce2), .we(we), .addr(addr), .sel(sel),
        .data_i(wdata), .data_o(q2), .stall_o(st2), .err_o(er2)
    );
    dm_ctrl #(.DEPTH(1024), .WAIT(3)) u3 (
        .clk(clk), .rst(rst3), .ce(ce3), .we(we), .addr(addr), .sel(sel),
        .data_i(wdata), .data_o(q3), .stall_o(st3), .err_o(er3)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    // Runs one access on u2 (which=2) or u3 (which=3); entered just after a rising edge.
    task automatic access(input int which, input logic w, input logic [31:0] a,
                          input logic [3:0] s, input logic [31:0] d,
                          output int stalls, output logic [31:0] q, output logic e);
        logic done;
        we = w; addr = a; sel = s; wdata = d;
        if (which == 3) ce3 = 1'b1; else ce2 = 1'b1;
        stalls = 0;
        done   = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if ((which == 3) ? st3 : st2) begin
                stalls++;
                @(posedge clk); #1;
            end else begin
                done = 1'b1;
                break;
            end
        end
        q = (which == 3) ? q3 : q2;
        e = (which == 3) ? er3 : er2;
        if (!done) begin
            n_vec++;
            n_fail++;
            $display("FAIL timeout: u%0d stall never released", which);
        end
        @(posedge clk); #1;
        ce2 = 1'b0;
        ce3 = 1'b0;
    endtask

    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [3:0]  s;
        logic [31:0] d;
        logic [31:0] exp_q;
        logic        exp_e;
    } vec_t;

    vec_t vecs[15];

    initial begin
        int          stalls;
        logic [31:0] q;
        logic        e;

        vecs = '{
            '{1'b1, 32'h40,   4'hF, 32'h11223344, 32'h00000000, 1'b0},
            '{1'b0, 32'h40,   4'hF, 32'h0,        32'h11223344, 1'b0},
            '{1'b1, 32'h40,   4'h5, 32'hAABBCCDD, 32'h11223344, 1'b0},
            '{1'b0, 32'h40,   4'hF, 32'h0,        32'h11BB33DD, 1'b0},
            '{1'b1, 32'h48,   4'hF, 32'h12345678, 32'h11BB33DD, 1'b0},
            '{1'b1, 32'h48,   4'h0, 32'hFFFFFFFF, 32'h11BB33DD, 1'b0},
            '{1'b0, 32'h48,   4'hF, 32'h0,        32'h12345678, 1'b0},
            '{1'b1, 32'h4F,   4'hF, 32'hCAFEBABE, 32'h12345678, 1'b0},
            '{1'b0, 32'h4C,   4'hF, 32'h0,        32'hCAFEBABE, 1'b0},
            '{1'b1, 32'h0,    4'hF, 32'h01020304, 32'hCAFEBABE, 1'b0},
            '{1'b1, 32'h1000, 4'hF, 32'hDEADBEEF, 32'hCAFEBABE, ERR_EN},
            '{1'b0, 32'h0,    4'hF, 32'h0,        ERR_EN ? 32'h01020304 : 32'hDEADBEEF, 1'b0},
            '{1'b0, 32'h1000, 4'hF, 32'h0,        ERR_EN ? 32'h00000000 : 32'hDEADBEEF, ERR_EN},
            '{1'b1, 32'h4C,   4'hA, 32'h00112233, ERR_EN ? 32'h00000000 : 32'hDEADBEEF, 1'b0},
            '{1'b0, 32'h4C,   4'hF, 32'h0,        32'h00FE22BE, 1'b0}
        };

        // Reset state, with async reset held low.
        #3;
        chk("rst u2 data", q2, 32'h0);
        chk("rst u2 stall", {31'b0, st2}, 32'h0);
        chk("rst u2 err", {31'b0, er2}, 32'h0);
        chk("rst u3 data", q3, 32'h0);
        chk("rst u0 data", q0, 32'h0);
        chk("rst u0 stall", {31'b0, st0}, 32'h0);
        @(negedge clk); rst = 1'b1; rst3 = 1'b1;
        @(posedge clk); #1;

        // WAIT=2 vector table: 3 stall cycles per access, data/err checked in DONE.
        for (int i = 0; i < 15; i++) begin
            access(2, vecs[i].w, vecs[i].a, vecs[i].s, vecs[i].d, stalls, q, e);
            chk($sformatf("v%0d stall cycles", i), 32'(stalls), 32'd3);
            chk($sformatf("v%0d data", i), q, vecs[i].exp_q);
            chk($sformatf("v%0d err", i), {31'b0, e}, {31'b0, vecs[i].exp_e});
        end

        // WAIT=0: combinational read, write commits on the edge.
        ce0 = 1'b1; we = 1'b1; addr = 32'h40; sel = 4'hF; wdata = 32'h11223344;
        @(negedge clk);
        chk("w0 write data_o", q0, 32'h0);
        chk("w0 write stall", {31'b0, st0}, 32'h0);
        @(posedge clk); #1;
        sel = 4'h5; wdata = 32'hAABBCCDD;
        @(posedge clk); #1;
        we = 1'b0; sel = 4'hF;
        #1;
        chk("w0 read data", q0, 32'h11BB33DD);
        chk("w0 read stall", {31'b0, st0}, 32'h0);
        chk("w0 read err", {31'b0, er0}, 32'h0);
        ce0 = 1'b0;
        #1;
        chk("w0 idle data", q0, 32'h0);
        ce0 = 1'b1; we = 1'b1; addr = 32'h0; wdata = 32'h55AA55AA;
        @(posedge clk); #1;
        addr = 32'h1000; wdata = 32'h77777777;
        #1;
        chk("w0 oor write err", {31'b0, er0}, {31'b0, ERR_EN});
        @(posedge clk); #1;
        we = 1'b0; addr = 32'h0;
        #1;
        chk("w0 alias read", q0, ERR_EN ? 32'h55AA55AA : 32'h77777777);
        chk("w0 alias err", {31'b0, er0}, 32'h0);
        ce0 = 1'b0;

        // WAIT=3: reset during BUSY discards the in-flight write.
        access(3, 1'b1, 32'h44, 4'hF, 32'h0BADF00D, stalls, q, e);
        chk("w3 write stalls", 32'(stalls), 32'd4);
        access(3, 1'b0, 32'h44, 4'hF, 32'h0, stalls, q, e);
        chk("w3 read stalls", 32'(stalls), 32'd4);
        chk("w3 read data", q, 32'h0BADF00D);
        we = 1'b1; addr = 32'h44; sel = 4'hF; wdata = 32'hFFFFFFFF; ce3 = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("w3 busy stall", {31'b0, st3}, 32'h1);
        rst3 = 1'b0; ce3 = 1'b0;
        #1;
        chk("w3 rst stall", {31'b0, st3}, 32'h0);
        chk("w3 rst data", q3, 32'h0);
        chk("w3 rst err", {31'b0, er3}, 32'h0);
        @(posedge clk); @(posedge clk); #1;
        rst3 = 1'b1;
        @(posedge clk); #1;
        access(3, 1'b0, 32'h44, 4'hF, 32'h0, stalls, q, e);
        chk("w3 post-rst stalls", 32'(stalls), 32'd4);
        chk("w3 post-rst data", q, 32'h0BADF00D);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
